// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM controller: command opcodes and FSM encoding.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPI_ACC = 2'd1,
    ST_LOC_ACC = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_t;

  // Opcodes 01 and 11 carry a RAM access; 00 and 10 only load an address latch.
  function automatic logic is_data_cmd(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Bundle of SPI command, local requester and RAM port signals around spi_ram_ctrl.
//
// Handshakes:
//   rx_valid   one-cycle strobe; rx_data is consumed on that edge, no back-pressure.
//   tx_valid   level; rises with read data, falls on the edge of the next rx_valid.
//   loc_req    held with loc_we/loc_addr/loc_wdata stable until loc_gnt is seen;
//              loc_gnt pulses one cycle in the cycle the RAM access is issued.
//   loc_rvalid one-cycle pulse qualifying loc_rdata, two cycles after a read grant.
//   mem_en     one-cycle access; mem_rdata is valid the cycle after a read enable.
interface spi_ram_ctrl_if #(
  parameter int ADDR_SIZE = 8
);
  logic [9:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 loc_req;
  logic                 loc_we;
  logic [ADDR_SIZE-1:0] loc_addr;
  logic [7:0]           loc_wdata;
  logic                 loc_gnt;
  logic [7:0]           loc_rdata;
  logic                 loc_rvalid;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem_rdata;
  logic                 spi_ovf;

  // Controller side.
  modport slave (
    input  rx_data, rx_valid, loc_req, loc_we, loc_addr, loc_wdata, mem_rdata,
    output tx_data, tx_valid, loc_gnt, loc_rdata, loc_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata, spi_ovf
  );

  // Environment side: SPI slave, local requester and RAM.
  modport master (
    output rx_data, rx_valid, loc_req, loc_we, loc_addr, loc_wdata, mem_rdata,
    input  tx_data, tx_valid, loc_gnt, loc_rdata, loc_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata, spi_ovf
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  // 1 means requester 1 was granted last; reset favours requester 0 on the first tie.
  logic last_one;

  // Grant the sole requester, or on a tie the one that did not win last time.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last_one);
    gnt[1] = req[1] & (~req[0] | ~last_one);
  end

  // Remember the winner only when the grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_one <= 1'b1;
    end else if (upd && (|gnt)) begin
      last_one <= gnt[1];
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI command words, holds write/read address latches and shares the
// single RAM port between the SPI command stream and a local requester.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 2 ** ADDR_SIZE
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_ctrl_if.slave  bus,
  output state_t         dbg_state
);

  state_t               state;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 spi_pend;
  logic                 pend_wr;
  logic [7:0]           pend_data;
  logic                 rd_for_loc;
  logic [1:0]           rx_op;
  logic [7:0]           rx_pay;
  logic [ADDR_SIZE-1:0] rx_addr;
  logic [1:0]           req;
  logic [1:0]           gnt;
  logic                 arb_upd;

  assign rx_op     = bus.rx_data[9:8];
  assign rx_pay    = bus.rx_data[7:0];
  // Wrap the payload into the RAM so an address latch never points past the array.
  assign rx_addr   = ADDR_SIZE'(32'(rx_pay) % MEM_DEPTH);
  assign req       = {bus.loc_req, spi_pend};
  assign arb_upd   = (state == ST_IDLE);
  assign dbg_state = state;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .upd   (arb_upd),
    .gnt   (gnt)
  );

  // Address latches; an access already issued keeps the address it captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (bus.rx_valid) begin
      if (rx_op == CMD_WR_ADDR) wr_addr <= rx_addr;
      if (rx_op == CMD_RD_ADDR) rd_addr <= rx_addr;
    end
  end

  // One-deep SPI command slot; a newer data command replaces an unserved one and flags overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_pend     <= 1'b0;
      pend_wr      <= 1'b0;
      pend_data    <= '0;
      bus.spi_ovf  <= 1'b0;
    end else if (bus.rx_valid && is_data_cmd(rx_op)) begin
      spi_pend  <= 1'b1;
      pend_wr   <= (rx_op == CMD_WR_DATA);
      pend_data <= rx_pay;
      if (spi_pend) bus.spi_ovf <= 1'b1;
    end else if (state == ST_SPI_ACC) begin
      spi_pend <= 1'b0;
    end
  end

  // Access sequencer: issue one RAM cycle per grant, then return read data to its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rd_for_loc     <= 1'b0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.loc_gnt    <= 1'b0;
      bus.loc_rdata  <= '0;
      bus.loc_rvalid <= 1'b0;
      bus.tx_data    <= '0;
      bus.tx_valid   <= 1'b0;
    end else begin
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.loc_gnt    <= 1'b0;
      bus.loc_rvalid <= 1'b0;
      if (bus.rx_valid) bus.tx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt[0]) begin
            state         <= ST_SPI_ACC;
            rd_for_loc    <= 1'b0;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= pend_wr;
            bus.mem_addr  <= pend_wr ? wr_addr : rd_addr;
            bus.mem_wdata <= pend_data;
          end else if (gnt[1]) begin
            state         <= ST_LOC_ACC;
            rd_for_loc    <= 1'b1;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.loc_we;
            bus.mem_addr  <= bus.loc_addr;
            bus.mem_wdata <= bus.loc_wdata;
            bus.loc_gnt   <= 1'b1;
          end
        end
        ST_SPI_ACC, ST_LOC_ACC: begin
          state <= bus.mem_we ? ST_IDLE : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (rd_for_loc) begin
            bus.loc_rdata  <= bus.mem_rdata;
            bus.loc_rvalid <= 1'b1;
          end else begin
            bus.tx_data  <= bus.mem_rdata;
            bus.tx_valid <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl with a behavioural single-port RAM and a write log.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     checks;
  int     errors;

  logic [7:0]  ram [256];
  logic [15:0] act_q[$];
  logic [15:0] exp_q[$];

  spi_ram_ctrl_if #(.ADDR_SIZE(8)) bus ();

  spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RAM model: synchronous write, read data one cycle after the enable; log every write.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        act_q.push_back({bus.mem_addr, bus.mem_wdata});
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [9:0] word);
    bus.rx_data  = word;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic loc_drive(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    bus.loc_req   = 1'b1;
    bus.loc_we    = we;
    bus.loc_addr  = addr;
    bus.loc_wdata = wdata;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
    bus.loc_req = 1'b0; bus.loc_we = 1'b0; bus.loc_addr = '0; bus.loc_wdata = '0;
    bus.mem_rdata = '0;
    exp_q = '{16'h12AB, 16'h345C, 16'h5011, 16'h6077, 16'h5055, 16'h6188, 16'h5066, 16'hA0BB};

    // Reset values
    repeat (3) step();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_spi_ovf", bus.spi_ovf, 1'b0);
    chk("rst_loc_gnt", bus.loc_gnt, 1'b0);
    rst_n = 1'b1;

    // SPI write 0x12 <- 0xAB
    send_rx(10'h012);
    send_rx(10'h1AB);
    chk("spiw_not_yet", bus.mem_en, 1'b0);
    step();
    chk("spiw_state", dbg_state, ST_SPI_ACC);
    chk("spiw_en", bus.mem_en, 1'b1);
    chk("spiw_we", bus.mem_we, 1'b1);
    chk("spiw_addr", bus.mem_addr, 8'h12);
    chk("spiw_wdata", bus.mem_wdata, 8'hAB);
    step();
    chk("spiw_idle", dbg_state, ST_IDLE);
    chk("spiw_en_off", bus.mem_en, 1'b0);

    // SPI read 0x12
    send_rx(10'h212);
    send_rx(10'h300);
    chk("spir_txv_n1", bus.tx_valid, 1'b0);
    step();
    chk("spir_en", bus.mem_en, 1'b1);
    chk("spir_we", bus.mem_we, 1'b0);
    chk("spir_addr", bus.mem_addr, 8'h12);
    step();
    chk("spir_wait", dbg_state, ST_RD_WAIT);
    chk("spir_txv_n3", bus.tx_valid, 1'b0);
    step();
    chk("spir_txv_n4", bus.tx_valid, 1'b1);
    chk("spir_txdata", bus.tx_data, 8'hAB);
    step();
    step();
    chk("spir_txv_hold", bus.tx_valid, 1'b1);
    send_rx(10'h000);
    chk("spir_txv_clr", bus.tx_valid, 1'b0);

    // Local write 0x34 <- 0x5C, then local read 0x34
    loc_drive(1'b1, 8'h34, 8'h5C);
    step();
    chk("locw_gnt", bus.loc_gnt, 1'b1);
    chk("locw_en", bus.mem_en, 1'b1);
    chk("locw_addr", bus.mem_addr, 8'h34);
    chk("locw_wdata", bus.mem_wdata, 8'h5C);
    bus.loc_req = 1'b0;
    step();
    chk("locw_gnt_off", bus.loc_gnt, 1'b0);
    chk("locw_idle", dbg_state, ST_IDLE);
    loc_drive(1'b0, 8'h34, 8'h00);
    step();
    chk("locr_gnt", bus.loc_gnt, 1'b1);
    chk("locr_we", bus.mem_we, 1'b0);
    bus.loc_req = 1'b0;
    step();
    chk("locr_rv_early", bus.loc_rvalid, 1'b0);
    step();
    chk("locr_rvalid", bus.loc_rvalid, 1'b1);
    chk("locr_rdata", bus.loc_rdata, 8'h5C);
    step();
    chk("locr_rv_pulse", bus.loc_rvalid, 1'b0);

    // Collisions after a fresh reset: SPI wins first, then strict alternation
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    send_rx(10'h050);
    send_rx(10'h111);
    loc_drive(1'b1, 8'h60, 8'h77);
    step();
    chk("col1_spi_first", dbg_state, ST_SPI_ACC);
    chk("col1_no_lgnt", bus.loc_gnt, 1'b0);
    chk("col1_spi_addr", bus.mem_addr, 8'h50);
    chk("col1_spi_data", bus.mem_wdata, 8'h11);
    step();
    chk("col1_idle", dbg_state, ST_IDLE);
    step();
    chk("col1_loc_next", dbg_state, ST_LOC_ACC);
    chk("col1_lgnt", bus.loc_gnt, 1'b1);
    chk("col1_loc_addr", bus.mem_addr, 8'h60);
    bus.loc_req = 1'b0;
    step();
    send_rx(10'h155);
    step();
    chk("solo_spi", dbg_state, ST_SPI_ACC);
    chk("solo_spi_data", bus.mem_wdata, 8'h55);
    step();
    send_rx(10'h166);
    loc_drive(1'b1, 8'h61, 8'h88);
    step();
    chk("col2_loc_first", dbg_state, ST_LOC_ACC);
    chk("col2_lgnt", bus.loc_gnt, 1'b1);
    chk("col2_loc_addr", bus.mem_addr, 8'h61);
    bus.loc_req = 1'b0;
    step();
    step();
    chk("col2_spi_next", dbg_state, ST_SPI_ACC);
    chk("col2_spi_data", bus.mem_wdata, 8'h66);
    step();

    // Overflow: two data commands while the local read holds the port
    send_rx(10'h0A0);
    chk("ovf_clear", bus.spi_ovf, 1'b0);
    loc_drive(1'b0, 8'h60, 8'h00);
    bus.rx_data  = 10'h1AA;
    bus.rx_valid = 1'b1;
    step();
    chk("ovf_loc_acc", dbg_state, ST_LOC_ACC);
    bus.loc_req  = 1'b0;
    bus.rx_data  = 10'h1BB;
    step();
    bus.rx_valid = 1'b0;
    chk("ovf_set", bus.spi_ovf, 1'b1);
    chk("ovf_rdwait", dbg_state, ST_RD_WAIT);
    step();
    chk("ovf_loc_rvalid", bus.loc_rvalid, 1'b1);
    chk("ovf_loc_rdata", bus.loc_rdata, 8'h77);
    step();
    chk("ovf_spi_acc", dbg_state, ST_SPI_ACC);
    chk("ovf_addr", bus.mem_addr, 8'hA0);
    chk("ovf_second_data", bus.mem_wdata, 8'hBB);
    step();
    chk("ovf_sticky", bus.spi_ovf, 1'b1);

    // Reset in the middle of a local write
    loc_drive(1'b1, 8'h70, 8'h99);
    step();
    chk("abort_in_acc", dbg_state, ST_LOC_ACC);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_en", bus.mem_en, 1'b0);
    chk("abort_mem_we", bus.mem_we, 1'b0);
    chk("abort_lgnt", bus.loc_gnt, 1'b0);
    chk("abort_ovf", bus.spi_ovf, 1'b0);
    chk("abort_state", dbg_state, ST_IDLE);
    bus.loc_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_rvalid", bus.loc_rvalid, 1'b0);
      chk("abort_idle", dbg_state, ST_IDLE);
    end

    // Write log against the expected queue
    chk("wlog_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) chk("wlog_entry", act_q[i], exp_q[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Controller that sits between the SPI slave and the single-port RAM. It decodes the 10-bit SPI command words, holds the write and read addresses, and shares the one RAM port between the SPI command stream and a local requester using round-robin arbitration. Read data is returned to the SPI slave on tx_data/tx_valid or to the local requester on loc_rdata/loc_rvalid.

## Interface
- ADDR_SIZE, 8, RAM address width
- MEM_DEPTH, 256, RAM depth (2**ADDR_SIZE)
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  10  SPI command word: [9:8] opcode, [7:0] payload
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  read data to SPI slave
- tx_valid  out  1  tx_data valid (level, see Operation)
- loc_req  in  1  local access request, held until loc_gnt
- loc_we  in  1  local write (1) / read (0), stable while loc_req
- loc_addr  in  ADDR_SIZE  local address, stable while loc_req
- loc_wdata  in  8  local write data, stable while loc_req
- loc_gnt  out  1  one-cycle pulse, local access issued
- loc_rdata  out  8  local read data
- loc_rvalid  out  1  one-cycle pulse, loc_rdata valid
- mem_en, mem_we  out  1 each  RAM port enable / write enable
- mem_addr  out  ADDR_SIZE  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, one cycle after the read-enable cycle
- spi_ovf  out  1  sticky: SPI data command arrived while a previous one was still pending

## Operation
- Opcodes: 00 = load wr_addr ← payload; 01 = write payload to wr_addr; 10 = load rd_addr ← payload; 11 = read rd_addr (payload ignored).
- Address opcodes update their latch on the rx_valid edge and never touch the RAM. An access already in flight keeps its captured address.
- Opcodes 01/11 set a 1-deep spi_pend register (opcode plus data). A second 01/11 arriving while spi_pend is set overwrites it and sets spi_ovf. spi_ovf clears only on reset.
- FSM states: IDLE, SPI_ACC, LOC_ACC, RD_WAIT.
- IDLE: if spi_pend and loc_req are both set, the winner is the requester not granted last. Otherwise the single requester wins. Otherwise stay in IDLE.
- SPI_ACC / LOC_ACC: last one cycle, with mem_en = 1. Go to RD_WAIT on a read, or to IDLE on a write. spi_pend clears on leaving SPI_ACC.
- RD_WAIT: mem_rdata is captured into tx_data or loc_rdata. Then go to IDLE.
- tx_valid rises with the captured SPI read data and stays high until the next rx_valid, which clears it on that edge.
- Reset values: all outputs 0, spi_pend = 0, latches = 0, last_grant = local (SPI wins the first tie).
- Reset mid-access aborts immediately. No RAM write completes after rst_n falls.

## Timing
- Request visible (spi_pend or loc_req) in IDLE during cycle n.
- Cycle n+1: state is ACC, mem_en/mem_we/mem_addr/mem_wdata registered and valid; loc_gnt = 1 if local.
- Write: complete at the end of n+1; IDLE again in n+2. A requester that drops loc_req after sampling loc_gnt is not re-granted.
- Read: mem_rdata valid in n+2 (RD_WAIT). loc_rvalid pulses, or tx_valid rises, in n+3.
- rx_valid in cycle n sets spi_pend at the end of n. Earliest SPI issue is n+2.
- Back-to-back: a new grant can be issued from IDLE on the cycle after a write or RD_WAIT. Two contenders alternate strictly.
- Address opcode and RAM access in the same cycle: both proceed; the access uses the old latch value.

## Structure
- Package spi_ram_pkg: opcode constants (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the FSM state encoding.
- Sub-module rr_arbiter2: two-requester round-robin with last_grant register and an update-on-grant input.

## Test plan
- Reset, then rx 0x0_12, 0x1_AB: mem_en = 1 and mem_we = 1 at addr 0x12 with wdata 0xAB, 2 cycles after the second rx_valid.
- rx 0x2_12, 0x3_00: mem read at 0x12. tx_data = 0xAB, and tx_valid rises 4 cycles after rx_valid and holds until the next rx_valid.
- Local write 0x34 ← 0x5C, then local read 0x34: loc_gnt pulses; loc_rvalid pulses with 0x5C 2 cycles after the read loc_gnt.
- SPI write pending and loc_req in the same cycle after reset: SPI granted first, local next cycle after IDLE. Repeat the collision: local granted first.
- Two 01 commands with no idle slot (loc holds port): spi_ovf = 1, only the second data is written.
- rst_n low during LOC_ACC of a write: all outputs 0 asynchronously, no loc_rvalid, FSM in IDLE after release.
